// File: rtl/matrix_xfade.sv
// Crossfading routing matrix: NUM_IN signed sources to NUM_OUT destinations.
// One sample strobe starts a serial pass through every output using a single shared multiplier.
//
// state | meaning (one instance per output)
// IDLE  | output follows src(cur_sel)
// FADE  | output blends src(cur_sel) -> src(tgt_sel); k counts fade samples

module matrix_xfade #(
    parameter int BITSIZE   = 16,
    parameter int NUM_IN    = 9,
    parameter int NUM_OUT   = 11,
    parameter int FADE_BITS = 6,
    parameter int SELW      = $clog2(NUM_IN + 1)
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       sample_strobe,
    input  logic [NUM_IN*BITSIZE-1:0]  in_bus,
    input  logic [NUM_OUT*SELW-1:0]    sel_bus,
    output logic [NUM_OUT*BITSIZE-1:0] out_bus,
    output logic                       busy,
    output logic                       done,
    output logic [NUM_OUT-1:0]         fading,
    output logic                       overrun
);

    localparam int JW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int KW = FADE_BITS + 1;
    localparam int DW = BITSIZE + 1;
    localparam int PW = BITSIZE + FADE_BITS + 2;
    localparam logic [KW-1:0] K_END = KW'(2 ** FADE_BITS);
    localparam logic [JW-1:0] J_LAST = JW'(NUM_OUT - 1);

    typedef enum logic {IDLE = 1'b0, FADE = 1'b1} xf_state_t;

    xf_state_t              st      [NUM_OUT];
    logic [SELW-1:0]        cur_sel [NUM_OUT];
    logic [SELW-1:0]        tgt_sel [NUM_OUT];
    logic [KW-1:0]          k_cnt   [NUM_OUT];

    logic [NUM_IN*BITSIZE-1:0] snap_in;
    logic [NUM_OUT*SELW-1:0]   snap_sel;
    logic                      run;
    logic [JW-1:0]             idx;

    // stage 1 (select and difference)
    logic                      accept;
    logic                      s1_go;
    logic [JW-1:0]             j1;
    logic [NUM_IN*BITSIZE-1:0] in1;
    logic [NUM_OUT*SELW-1:0]   sel_src;
    logic [SELW-1:0]           sel1;
    logic [SELW-1:0]           tsel1;
    logic [KW-1:0]             kn1;
    logic                      fade1;
    logic signed [BITSIZE-1:0] a1;
    logic signed [BITSIZE-1:0] b1;

    logic                      s1_vld;
    logic [JW-1:0]             s1_idx;
    logic signed [BITSIZE-1:0] s1_a;
    logic signed [DW-1:0]      s1_d;
    logic [KW-1:0]             s1_k;
    logic                      s1_fade;
    logic [SELW-1:0]           s1_tgt;

    // stage 2 (multiply, shift, add, state update)
    logic signed [PW-1:0]      d_ext;
    logic signed [PW-1:0]      k_ext;
    logic signed [PW-1:0]      prod;
    logic [BITSIZE-1:0]        o2;
    xf_state_t                 st_nxt;
    logic [SELW-1:0]           cur_nxt;
    logic [SELW-1:0]           tgt_nxt;
    logic [KW-1:0]             k_nxt;

    // Any select code >= NUM_IN yields silence.
    function automatic logic signed [BITSIZE-1:0] src_of(
        input logic [NUM_IN*BITSIZE-1:0] bus,
        input logic [SELW-1:0]           sel
    );
        logic signed [BITSIZE-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SELW'(i)) v = bus[i*BITSIZE +: BITSIZE];
        end
        return v;
    endfunction

    // Slot 0 is evaluated on the accepting edge straight from the live buses,
    // which carry the same values the snapshot captures on that edge.
    always_comb begin
        accept  = sample_strobe && !busy;
        s1_go   = accept || run;
        j1      = accept ? '0 : idx;
        in1     = accept ? in_bus : snap_in;
        sel_src = accept ? sel_bus : snap_sel;
        sel1    = sel_src[j1*SELW +: SELW];
        tsel1   = tgt_sel[j1];
        kn1     = '0;
        fade1   = 1'b0;
        if (st[j1] == FADE) begin
            fade1 = 1'b1;
            kn1   = k_cnt[j1] + KW'(1);
        end else if (sel1 != cur_sel[j1]) begin
            fade1 = 1'b1;
            kn1   = KW'(1);
            tsel1 = sel1;
        end
        a1 = src_of(in1, cur_sel[j1]);
        b1 = fade1 ? src_of(in1, tsel1) : a1;
    end

    always_comb begin
        d_ext   = PW'(s1_d);
        k_ext   = PW'(s1_k);
        prod    = d_ext * k_ext;
        o2      = BITSIZE'(s1_a + (prod >>> FADE_BITS));
        st_nxt  = st[s1_idx];
        cur_nxt = cur_sel[s1_idx];
        tgt_nxt = tgt_sel[s1_idx];
        k_nxt   = k_cnt[s1_idx];
        if (s1_fade) begin
            if (s1_k == K_END) begin
                st_nxt  = IDLE;
                cur_nxt = s1_tgt;
                tgt_nxt = s1_tgt;
                k_nxt   = '0;
            end else begin
                st_nxt  = FADE;
                tgt_nxt = s1_tgt;
                k_nxt   = s1_k;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_bus  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
            snap_in  <= '0;
            snap_sel <= '0;
            run      <= 1'b0;
            idx      <= '0;
            s1_vld   <= 1'b0;
            s1_idx   <= '0;
            s1_a     <= '0;
            s1_d     <= '0;
            s1_k     <= '0;
            s1_fade  <= 1'b0;
            s1_tgt   <= '0;
            for (int i = 0; i < NUM_OUT; i++) begin
                st[i]      <= IDLE;
                cur_sel[i] <= '1;
                tgt_sel[i] <= '1;
                k_cnt[i]   <= '0;
            end
        end else begin
            if (sample_strobe && busy) overrun <= 1'b1;

            if (accept) begin
                snap_in  <= in_bus;
                snap_sel <= sel_bus;
                busy     <= 1'b1;
            end else if (done) begin
                busy <= 1'b0;
            end

            if (accept) begin
                run <= (NUM_OUT > 1);
                idx <= JW'(1);
            end else if (run) begin
                if (idx == J_LAST) run <= 1'b0;
                else               idx <= idx + JW'(1);
            end

            s1_vld <= s1_go;
            if (s1_go) begin
                s1_idx  <= j1;
                s1_a    <= a1;
                s1_d    <= {b1[BITSIZE-1], b1} - {a1[BITSIZE-1], a1};
                s1_k    <= kn1;
                s1_fade <= fade1;
                s1_tgt  <= tsel1;
            end

            done <= s1_vld && (s1_idx == J_LAST);
            if (s1_vld) begin
                out_bus[s1_idx*BITSIZE +: BITSIZE] <= o2;
                st[s1_idx]      <= st_nxt;
                cur_sel[s1_idx] <= cur_nxt;
                tgt_sel[s1_idx] <= tgt_nxt;
                k_cnt[s1_idx]   <= k_nxt;
            end
        end
    end

    always_comb begin
        fading = '0;
        for (int j = 0; j < NUM_OUT; j++) fading[j] = (st[j] == FADE);
    end

endmodule

// File: tb/tb_matrix_xfade.sv
// Self-checking bench for matrix_xfade: fixed fade tables, hand-written timing/reset
// sequences, and random patching checked against a per-strobe arithmetic model.

module tb_matrix_xfade;

    localparam int BITSIZE   = 16;
    localparam int NUM_IN    = 9;
    localparam int NUM_OUT   = 11;
    localparam int FADE_BITS = 6;
    localparam int SELW      = $clog2(NUM_IN + 1);
    localparam int IW        = NUM_IN * BITSIZE;
    localparam int SW        = NUM_OUT * SELW;
    localparam int OW        = NUM_OUT * BITSIZE;
    localparam int NSTEP     = 1 << FADE_BITS;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          sample_strobe = 1'b0;
    logic [IW-1:0] in_bus = '0;
    logic [SW-1:0] sel_bus = '0;
    logic [OW-1:0] out_bus;
    logic          busy;
    logic          done;
    logic [NUM_OUT-1:0] fading;
    logic          overrun;

    matrix_xfade #(
        .BITSIZE(BITSIZE), .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .FADE_BITS(FADE_BITS)
    ) dut (
        .clk(clk), .resetn(resetn), .sample_strobe(sample_strobe),
        .in_bus(in_bus), .sel_bus(sel_bus), .out_bus(out_bus),
        .busy(busy), .done(done), .fading(fading), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // model state: one entry per destination
    int m_cur [NUM_OUT];
    int m_tgt [NUM_OUT];
    int m_k   [NUM_OUT];
    bit m_fade[NUM_OUT];
    int m_out [NUM_OUT];

    logic [IW-1:0] cur_in;
    logic [SW-1:0] cur_sel;

    typedef struct {
        int val;
        int n;
        int exp_out;
        bit exp_fade;
    } fade_vec_t;

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic int chan(input logic [IW-1:0] v, input int i);
        logic signed [BITSIZE-1:0] s;
        s = v[i*BITSIZE +: BITSIZE];
        return int'(s);
    endfunction

    function automatic int src(input logic [IW-1:0] v, input int sel);
        return (sel < NUM_IN) ? chan(v, sel) : 0;
    endfunction

    function automatic int floor_div(input int x, input int n);
        int q;
        q = x / n;
        if ((x % n != 0) && (x < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int dut_out(input int j);
        logic signed [BITSIZE-1:0] s;
        s = out_bus[j*BITSIZE +: BITSIZE];
        return int'(s);
    endfunction

    function automatic logic [IW-1:0] put_in(input logic [IW-1:0] v, input int i, input int val);
        v[i*BITSIZE +: BITSIZE] = BITSIZE'(val);
        return v;
    endfunction

    function automatic logic [SW-1:0] put_sel(input logic [SW-1:0] v, input int j, input int s);
        v[j*SELW +: SELW] = SELW'(s);
        return v;
    endfunction

    function automatic logic [IW-1:0] rand_in();
        logic [IW-1:0] v;
        for (int i = 0; i < NUM_IN; i++) v[i*BITSIZE +: BITSIZE] = BITSIZE'($urandom);
        return v;
    endfunction

    function automatic logic [SW-1:0] rand_sel();
        logic [SW-1:0] v;
        for (int j = 0; j < NUM_OUT; j++) v[j*SELW +: SELW] = SELW'($urandom);
        return v;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < NUM_OUT; j++) begin
            m_cur[j] = (1 << SELW) - 1;
            m_tgt[j] = (1 << SELW) - 1;
            m_k[j] = 0;
            m_fade[j] = 1'b0;
            m_out[j] = 0;
        end
    endtask

    // One accepted strobe: every destination advances one sample.
    task automatic model_step(input logic [IW-1:0] iv, input logic [SW-1:0] sv);
        int s, a, b;
        for (int j = 0; j < NUM_OUT; j++) begin
            s = int'(sv[j*SELW +: SELW]);
            if (!m_fade[j] && s != m_cur[j]) begin
                m_tgt[j] = s;
                m_k[j] = 0;
                m_fade[j] = 1'b1;
            end
            a = src(iv, m_cur[j]);
            if (m_fade[j]) begin
                m_k[j]++;
                b = src(iv, m_tgt[j]);
                m_out[j] = a + floor_div((b - a) * m_k[j], NSTEP);
                if (m_k[j] == NSTEP) begin
                    m_cur[j] = m_tgt[j];
                    m_fade[j] = 1'b0;
                end
            end else begin
                m_out[j] = a;
            end
        end
    endtask

    function automatic logic [OW-1:0] model_bus();
        logic [OW-1:0] v;
        for (int j = 0; j < NUM_OUT; j++) v[j*BITSIZE +: BITSIZE] = BITSIZE'(m_out[j]);
        return v;
    endfunction

    function automatic logic [OW-1:0] model_fading();
        logic [OW-1:0] v;
        v = '0;
        for (int j = 0; j < NUM_OUT; j++) v[j] = m_fade[j];
        return v;
    endfunction

    task automatic apply_reset();
        resetn = 1'b0;
        sample_strobe = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        model_reset();
    endtask

    // Called on a negedge; returns on a negedge gap cycles later. Buses are
    // scrambled after the strobe so only the snapshot can produce correct results.
    task automatic do_pass(input logic [IW-1:0] iv, input logic [SW-1:0] sv,
                           input int gap, input string tag);
        int seen_done;
        in_bus = iv;
        sel_bus = sv;
        sample_strobe = 1'b1;
        @(negedge clk);
        sample_strobe = 1'b0;
        in_bus = rand_in();
        sel_bus = rand_sel();
        seen_done = 0;
        for (int c = 1; c < gap; c++) begin
            if (done) seen_done++;
            @(negedge clk);
        end
        model_step(iv, sv);
        chk_int({tag, " done count"}, seen_done, 1);
        chk({tag, " out_bus"}, out_bus, model_bus());
        chk({tag, " fading"}, OW'(fading), model_fading());
    endtask

    initial begin
        fade_vec_t tab [8];
        logic [OW-1:0] old_bus, new_bus, exp_bus;
        int cnt, prev_val;

        tab[0] = '{1000, 1, 15, 1'b1};
        tab[1] = '{1000, 32, 500, 1'b1};
        tab[2] = '{1000, 63, 984, 1'b1};
        tab[3] = '{1000, 64, 1000, 1'b0};
        tab[4] = '{1000, 66, 1000, 1'b0};
        tab[5] = '{-1000, 1, -16, 1'b1};
        tab[6] = '{-1000, 32, -500, 1'b1};
        tab[7] = '{-1000, 64, -1000, 1'b0};

        // reset state
        repeat (2) @(negedge clk);
        chk("reset out_bus", out_bus, '0);
        chk("reset busy", OW'(busy), '0);
        chk("reset done", OW'(done), '0);
        chk("reset fading", OW'(fading), '0);
        chk("reset overrun", OW'(overrun), '0);

        // fade-in tables from reset
        cnt = 0;
        prev_val = 0;
        for (int e = 0; e < 8; e++) begin
            if (e == 0 || tab[e].val != prev_val) begin
                apply_reset();
                cnt = 0;
                cur_in = '0;
                cur_sel = '1;
                cur_in = put_in(cur_in, 0, tab[e].val);
                cur_sel = put_sel(cur_sel, 0, 0);
                prev_val = tab[e].val;
            end
            while (cnt < tab[e].n) begin
                do_pass(cur_in, cur_sel, 20, "fade_in");
                cnt++;
            end
            chk_int($sformatf("tab%0d out0 strobe %0d", e, tab[e].n), dut_out(0), tab[e].exp_out);
            chk($sformatf("tab%0d fading0", e), OW'(fading[0]), OW'(tab[e].exp_fade));
        end

        // source switch on out3, with bystanders out0, out5, out7
        apply_reset();
        cur_in = '0;
        cur_sel = '1;
        cur_in = put_in(cur_in, 0, 1234);
        cur_in = put_in(cur_in, 1, 8000);
        cur_in = put_in(cur_in, 2, -8000);
        cur_in = put_in(cur_in, 4, 5000);
        cur_in = put_in(cur_in, 5, -3210);
        cur_in = put_in(cur_in, 7, 3000);
        cur_sel = put_sel(cur_sel, 0, 0);
        cur_sel = put_sel(cur_sel, 3, 1);
        cur_sel = put_sel(cur_sel, 5, 4);
        cur_sel = put_sel(cur_sel, 7, 5);
        for (int n = 1; n <= NSTEP; n++) do_pass(cur_in, cur_sel, 15, "settle");
        chk_int("switch settled out3", dut_out(3), 8000);
        cur_sel = put_sel(cur_sel, 3, 2);
        for (int n = 1; n <= NSTEP; n++) begin
            do_pass(cur_in, cur_sel, 15, "switch");
            if (n == 1)  chk_int("switch out3 k=1", dut_out(3), 7750);
            if (n == 32) chk_int("switch out3 k=32", dut_out(3), 0);
        end
        chk_int("switch out3 k=64", dut_out(3), -8000);
        chk_int("switch bystander out0", dut_out(0), 1234);
        chk_int("switch bystander out7", dut_out(7), -3210);

        // mute on out5, reselect at strobe 10 must not retarget
        cur_sel = put_sel(cur_sel, 5, 12);
        for (int n = 1; n <= NSTEP + 1; n++) begin
            if (n == 10) cur_sel = put_sel(cur_sel, 5, 7);
            do_pass(cur_in, cur_sel, 14, "mute");
            if (n == 11) chk_int("mute out5 k=11", dut_out(5), 4140);
            if (n == 32) chk_int("mute out5 k=32", dut_out(5), 2500);
            if (n == NSTEP) begin
                chk_int("mute out5 k=64", dut_out(5), 0);
                chk("mute fading5 end", OW'(fading[5]), '0);
            end
        end
        chk_int("refade out5 k=1", dut_out(5), 46);
        chk("refade fading5", OW'(fading[5]), OW'(1));

        // per-cycle timing, ignored strobe at t+5 sets sticky overrun
        apply_reset();
        cur_in = '0;
        for (int i = 0; i < NUM_IN; i++) cur_in = put_in(cur_in, i, 1000 * (i + 1));
        for (int j = 0; j < NUM_OUT; j++) cur_sel = put_sel(cur_sel, j, j % NUM_IN);
        old_bus = model_bus();
        model_step(cur_in, cur_sel);
        new_bus = model_bus();
        in_bus = cur_in;
        sel_bus = cur_sel;
        sample_strobe = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            sample_strobe = (c == 5);
            if (c == 1 || c == 5) begin
                in_bus = rand_in();
                sel_bus = rand_sel();
            end
            exp_bus = old_bus;
            for (int j = 0; j < NUM_OUT; j++)
                if (c >= 2 + j) exp_bus[j*BITSIZE +: BITSIZE] = new_bus[j*BITSIZE +: BITSIZE];
            chk($sformatf("timing out_bus t+%0d", c), out_bus, exp_bus);
            chk($sformatf("timing busy t+%0d", c), OW'(busy), OW'(c <= 12));
            chk($sformatf("timing done t+%0d", c), OW'(done), OW'(c == 12));
            chk($sformatf("timing overrun t+%0d", c), OW'(overrun), OW'(c >= 6));
        end
        do_pass(cur_in, cur_sel, 20, "post_overrun");
        chk("overrun sticky", OW'(overrun), OW'(1));

        // reset in the middle of a pass
        in_bus = cur_in;
        sel_bus = cur_sel;
        sample_strobe = 1'b1;
        @(negedge clk);
        sample_strobe = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("midreset out_bus", out_bus, '0);
        chk("midreset fading", OW'(fading), '0);
        chk("midreset busy", OW'(busy), '0);
        chk("midreset overrun", OW'(overrun), '0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        model_reset();
        do_pass(cur_in, cur_sel, 16, "after_reset");
        chk_int("after_reset out0 k=1", dut_out(0), 15);
        chk("after_reset fading all", OW'(fading), OW'({NUM_OUT{1'b1}}));

        // random patching against the model
        apply_reset();
        cur_sel = rand_sel();
        for (int p = 0; p < 150; p++) begin
            cur_in = rand_in();
            for (int j = 0; j < NUM_OUT; j++)
                if ($urandom_range(0, 15) == 0)
                    cur_sel = put_sel(cur_sel, j, int'($urandom_range(0, (1 << SELW) - 1)));
            do_pass(cur_in, cur_sel, int'($urandom_range(13, 17)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
